pc_link_unit: RTL and testbench

Program-counter datapath stage directly downstream of the sequence controller. It holds the PC, advances it, and loads it from a branch target, the register file, or a hardware return-address (link) stack. It consumes the controller's active-low PC_Rst, PC_Inc, PC_Ld, STK_Ld and its PC_Src, BRA_Src selects. It drives the address that the fetch path routes to memory.

---
 rtl/pc_link_unit.sv | 132 +++++++++++++
 tb/tb_pc_link_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_link_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_link_unit
//   Program counter with branch/register/return-stack load paths and a
//   circular hardware link stack with sticky overflow/underflow flags.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module pc_link_unit #(
  parameter int                   DataWidth   = 16,
  parameter int                   StackDepth  = 4,
  parameter logic [DataWidth-1:0] ResetVector = '0
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          PC_Rst,
  input  logic                          PC_Inc,
  input  logic                          PC_Ld,
  input  logic [1:0]                    PC_Src,
  input  logic                          STK_Ld,
  input  logic                          BRA_Src,
  input  logic [15:0]                   IR,
  input  logic [DataWidth-1:0]          Src1Data,
  output logic [DataWidth-1:0]          PC_Out,
  output logic [DataWidth-1:0]          Stk_Top,
  output logic [$clog2(StackDepth):0]   Stk_Count,
  output logic                          Stk_Ovf,
  output logic                          Stk_Unf
);

  localparam int                  c_ptr_w = $clog2(StackDepth);
  localparam logic [c_ptr_w:0]    c_full  = (c_ptr_w+1)'(StackDepth);
  localparam logic [1:0]          c_src_branch = 2'b00;
  localparam logic [1:0]          c_src_pop    = 2'b01;
  localparam logic [1:0]          c_src_reg    = 2'b10;

  logic [DataWidth-1:0] r_pc;
  logic [DataWidth-1:0] r_stack [StackDepth];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 r_ovf;
  logic                 r_unf;

  logic [DataWidth-1:0] w_top;
  logic [DataWidth-1:0] w_branch;
  logic [DataWidth-1:0] w_pc_next;
  logic [c_ptr_w-1:0]   w_top_idx;
  logic [c_ptr_w-1:0]   w_wr_idx;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_unused_ir;

  assign w_unused_ir = ^IR[15:10];

  assign w_top_idx = r_wr_ptr - c_ptr_w'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_full);
  assign w_top     = w_empty ? ResetVector : r_stack[w_top_idx];
  assign w_push    = ~STK_Ld;
  assign w_pop     = ~PC_Ld & (PC_Src == c_src_pop);
  assign w_branch  = r_pc + {{(DataWidth-10){IR[9]}}, IR[9:0]};
  // A push that coincides with a pop replaces the top entry in place
  assign w_wr_idx  = (w_pop && !w_empty) ? w_top_idx : r_wr_ptr;

  always_comb begin
    w_pc_next = r_pc;
    if (!PC_Ld) begin
      case (PC_Src)
        c_src_branch: w_pc_next = BRA_Src ? w_branch : Src1Data;
        c_src_pop:    w_pc_next = w_top;
        c_src_reg:    w_pc_next = Src1Data;
        default:      w_pc_next = r_pc;
      endcase
    end else if (!PC_Inc) begin
      w_pc_next = r_pc + DataWidth'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc     <= ResetVector;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (!PC_Rst) begin
      r_pc     <= ResetVector;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_push && w_pop) begin
        if (w_empty) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
          r_count  <= (c_ptr_w+1)'(1);
          r_unf    <= 1'b1;
        end
      end else if (w_push) begin
        // Full stack wraps and overwrites the oldest entry
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
        if (w_full) r_ovf <= 1'b1;
        else        r_count <= r_count + (c_ptr_w+1)'(1);
      end else if (w_pop) begin
        if (w_empty) begin
          r_unf <= 1'b1;
        end else begin
          r_wr_ptr <= w_top_idx;
          r_count  <= r_count - (c_ptr_w+1)'(1);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < StackDepth; i++) r_stack[i] <= '0;
    end else if (PC_Rst && w_push) begin
      r_stack[w_wr_idx] <= r_pc;
    end
  end

  assign PC_Out    = r_pc;
  assign Stk_Top   = w_top;
  assign Stk_Count = r_count;
  assign Stk_Ovf   = r_ovf;
  assign Stk_Unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_link_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pc_link_unit
//   Directed and randomized checks of pc_link_unit against a queue model.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_pc_link_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        PC_Rst = 1'b1, PC_Inc = 1'b1, PC_Ld = 1'b1, STK_Ld = 1'b1, BRA_Src = 1'b0;
  logic [1:0]  PC_Src = 2'b00;
  logic [15:0] IR = '0, Src1Data = '0;
  logic [15:0] PC_Out, Stk_Top;
  logic [2:0]  Stk_Count;
  logic        Stk_Ovf, Stk_Unf;

  pc_link_unit dut (
    .Clk(Clk), .Reset(Reset), .PC_Rst(PC_Rst), .PC_Inc(PC_Inc), .PC_Ld(PC_Ld),
    .PC_Src(PC_Src), .STK_Ld(STK_Ld), .BRA_Src(BRA_Src), .IR(IR),
    .Src1Data(Src1Data), .PC_Out(PC_Out), .Stk_Top(Stk_Top),
    .Stk_Count(Stk_Count), .Stk_Ovf(Stk_Ovf), .Stk_Unf(Stk_Unf)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: PC value plus a queue holding the stack, newest at back
  logic [15:0] m_pc;
  logic [15:0] m_q[$];
  logic        m_ovf, m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_top();
    return (m_q.size() == 0) ? 16'h0000 : m_q[m_q.size()-1];
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] old_pc;
    logic        push, pop;
    int          off;
    old_pc = m_pc;
    if (!PC_Rst) begin
      model_reset();
      return;
    end
    push = !STK_Ld;
    pop  = !PC_Ld && PC_Src == 2'd1;
    if (!PC_Ld) begin
      off = IR[9] ? int'(IR[9:0]) - 1024 : int'(IR[9:0]);
      case (PC_Src)
        2'd0: m_pc = BRA_Src ? 16'(int'(old_pc) + off) : Src1Data;
        2'd1: m_pc = m_top();
        2'd2: m_pc = Src1Data;
        default: m_pc = old_pc;
      endcase
    end else if (!PC_Inc) begin
      m_pc = 16'(int'(old_pc) + 1);
    end
    if (push && pop) begin
      if (m_q.size() == 0) begin
        m_q.push_back(old_pc);
        m_unf = 1'b1;
      end else begin
        m_q[m_q.size()-1] = old_pc;
      end
    end else if (push) begin
      if (m_q.size() == 4) begin
        void'(m_q.pop_front());
        m_ovf = 1'b1;
      end
      m_q.push_back(old_pc);
    end else if (pop) begin
      if (m_q.size() == 0) m_unf = 1'b1;
      else void'(m_q.pop_back());
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},  32'(PC_Out),    32'(m_pc));
    check({tag, ".top"}, 32'(Stk_Top),   32'(m_top()));
    check({tag, ".cnt"}, 32'(Stk_Count), 32'(m_q.size()));
    check({tag, ".ovf"}, 32'(Stk_Ovf),   32'(m_ovf));
    check({tag, ".unf"}, 32'(Stk_Unf),   32'(m_unf));
  endtask

  // One clock: apply strobes, take the edge, advance the model, compare
  task automatic cyc(input string tag, input logic rst_b, input logic inc_b, input logic ld_b,
                     input logic [1:0] src, input logic stk_b, input logic bra,
                     input logic [15:0] ir, input logic [15:0] s1);
    PC_Rst = rst_b; PC_Inc = inc_b; PC_Ld = ld_b; PC_Src = src;
    STK_Ld = stk_b; BRA_Src = bra; IR = ir; Src1Data = s1;
    @(posedge Clk);
    model_step();
    #1;
    check_all(tag);
    PC_Rst = 1'b1; PC_Inc = 1'b1; PC_Ld = 1'b1; STK_Ld = 1'b1;
  endtask

  task automatic load(input logic [15:0] v);
    cyc("load", 1, 1, 0, 2'd2, 1, 0, 16'h0, v);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge Clk);
    Reset = 1'b1;

    // Asynchronous reset mid-cycle
    load(16'h0123);
    check("pc_0123", 32'(PC_Out), 32'h0123);
    #2 Reset = 1'b0;
    #1;
    check("async_rst_pc", 32'(PC_Out), 32'h0000);
    model_reset();
    check_all("async_rst");
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 3; i++) cyc("inc", 1, 0, 1, 2'd0, 1, 0, 16'h0, 16'h0);
    check("inc3", 32'(PC_Out), 32'h0003);
    load(16'hFFFF);
    cyc("wrap", 1, 0, 1, 2'd0, 1, 0, 16'h0, 16'h0);
    check("wrap0", 32'(PC_Out), 32'h0000);

    // Branches
    load(16'h0010);
    cyc("br_neg", 1, 1, 0, 2'd0, 1, 1, 16'h03FE, 16'h0);
    check("br_neg_v", 32'(PC_Out), 32'h000E);
    load(16'h0010);
    cyc("br_pos", 1, 1, 0, 2'd0, 1, 1, 16'h01FF, 16'h0);
    check("br_pos_v", 32'(PC_Out), 32'h020F);
    cyc("br_reg", 1, 1, 0, 2'd0, 1, 0, 16'h01FF, 16'h4000);
    check("br_reg_v", 32'(PC_Out), 32'h4000);

    // JPL / RET
    load(16'h0021);
    cyc("jpl", 1, 1, 0, 2'd2, 0, 0, 16'h0, 16'h0100);
    check("jpl_pc", 32'(PC_Out), 32'h0100);
    check("jpl_top", 32'(Stk_Top), 32'h0021);
    check("jpl_cnt", 32'(Stk_Count), 32'd1);
    cyc("ret", 1, 1, 0, 2'd1, 1, 0, 16'h0, 16'h0);
    check("ret_pc", 32'(PC_Out), 32'h0021);
    check("ret_cnt", 32'(Stk_Count), 32'd0);

    // Overflow: push 1..5 into a 4-deep stack
    for (int i = 1; i <= 5; i++) begin
      load(16'(i));
      cyc("push", 1, 1, 1, 2'd0, 0, 0, 16'h0, 16'h0);
    end
    check("ovf_cnt", 32'(Stk_Count), 32'd4);
    check("ovf_flag", 32'(Stk_Ovf), 32'd1);
    for (int i = 5; i >= 2; i--) begin
      cyc("pop", 1, 1, 0, 2'd1, 1, 0, 16'h0, 16'h0);
      check("pop_val", 32'(PC_Out), 32'(i));
    end

    // Underflow then PC_Rst overriding load and increment
    cyc("unf", 1, 1, 0, 2'd1, 1, 0, 16'h0, 16'h0);
    check("unf_pc", 32'(PC_Out), 32'h0000);
    check("unf_flag", 32'(Stk_Unf), 32'd1);
    load(16'h0777);
    cyc("pcrst", 0, 0, 0, 2'd2, 0, 0, 16'h0, 16'h1234);
    check("pcrst_pc", 32'(PC_Out), 32'h0000);
    check("pcrst_flags", 32'({Stk_Ovf, Stk_Unf}), 32'd0);
    check("pcrst_cnt", 32'(Stk_Count), 32'd0);

    // Priority and simultaneous push/pop
    cyc("ld_inc", 1, 0, 0, 2'd2, 1, 0, 16'h0, 16'h0070);
    check("ld_wins", 32'(PC_Out), 32'h0070);
    cyc("src11", 1, 1, 0, 2'd3, 1, 0, 16'h0, 16'hBEEF);
    check("src11_hold", 32'(PC_Out), 32'h0070);
    load(16'h0050);
    cyc("push50", 1, 1, 1, 2'd0, 0, 0, 16'h0, 16'h0);
    load(16'h0060);
    cyc("pushpop", 1, 1, 0, 2'd1, 0, 0, 16'h0, 16'h0);
    check("pp_pc", 32'(PC_Out), 32'h0050);
    check("pp_top", 32'(Stk_Top), 32'h0060);
    check("pp_cnt", 32'(Stk_Count), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic       rst_b, inc_b, ld_b, stk_b, bra;
      logic [1:0] src;
      rst_b = ($urandom_range(0, 39) != 0);
      inc_b = $urandom_range(0, 1) == 1;
      ld_b  = $urandom_range(0, 2) != 0;
      stk_b = $urandom_range(0, 2) != 0;
      bra   = $urandom_range(0, 1) == 1;
      src   = 2'($urandom_range(0, 3));
      cyc("rnd", rst_b, inc_b, ld_b, src, stk_b, bra, 16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
